data_io_dma_ctrl: RTL and testbench

// Sequences word transfers between the SPI data_io interface and system RAM.

---
 rtl/data_io_dma_if.sv | 32 +++
 rtl/data_io_dma_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_data_io_dma_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_io_dma_if.sv
// data_io strobe/register side and RAM request/ack side of data_io_dma_ctrl.
interface data_io_dma_if #(
    parameter int ADDR_WIDTH = 23
);
    logic                  addr_strobe;
    logic [31:0]           addr_reg;
    logic                  data_in_strobe;
    logic [15:0]           data_in_reg;
    logic                  data_out_strobe;
    logic [15:0]           data_out_reg;
    logic                  ram_req;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [15:0]           ram_din;
    logic [15:0]           ram_dout;
    logic                  ram_ack;
    logic                  busy;
    logic                  done;
    logic                  overrun;

    modport master (
        input  addr_strobe, addr_reg, data_in_strobe, data_in_reg, data_out_strobe,
               ram_dout, ram_ack,
        output data_out_reg, ram_req, ram_we, ram_addr, ram_din, busy, done, overrun
    );

    modport slave (
        output addr_strobe, addr_reg, data_in_strobe, data_in_reg, data_out_strobe,
               ram_dout, ram_ack,
        input  data_out_reg, ram_req, ram_we, ram_addr, ram_din, busy, done, overrun
    );
endinterface

// File: rtl/data_io_dma_ctrl.sv
// Block DMA between data_io toggle strobes and a req/ack RAM port; DIO_BYTESWAP_EN swaps RAM data bytes.
// IDLE: wait for addr | WR: FIFO drained to RAM | RD_FETCH: read in flight | RD_HOLD: word waits for IO | ABORT: finish granted access, restart
module data_io_dma_ctrl #(
    parameter int ADDR_WIDTH = 23,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    data_io_dma_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR       = 3'd1;
    localparam logic [2:0] S_RD_FETCH = 3'd2;
    localparam logic [2:0] S_RD_HOLD  = 3'd3;
    localparam logic [2:0] S_ABORT    = 3'd4;

    logic [2:0]            state_q, state_d;
    logic                  addr_tog_q, din_tog_q, dout_tog_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           words_q, words_d;
    logic [15:0]           push_rem_q, push_rem_d;
    logic                  dir_q, dir_d;
    logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [15:0]           fifo_mem [FIFO_DEPTH];
    logic                  ram_req_q, ram_req_d, ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [15:0]           ram_din_q, ram_din_d, dout_q, dout_d;
    logic                  busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;

    logic                  addr_ev, din_ev, dout_ev, ack;
    logic                  push, pop, flush;
    logic [PW:0]           fifo_cnt;
    logic                  fifo_full, fifo_empty;
    logic [15:0]           new_words;

`ifdef DIO_BYTESWAP_EN
    function automatic logic [15:0] fmt(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction
`else
    function automatic logic [15:0] fmt(input logic [15:0] w);
        return w;
    endfunction
`endif

    assign addr_ev    = bus.addr_strobe ^ addr_tog_q;
    assign din_ev     = bus.data_in_strobe ^ din_tog_q;
    assign dout_ev    = bus.data_out_strobe ^ dout_tog_q;
    assign ack        = bus.ram_ack & ram_req_q;
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign new_words  = {bus.addr_reg[31:24], 8'h00};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        push_rem_d = push_rem_q;
        dir_d      = dir_q;
        ram_req_d  = ram_req_q & ~ack;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        dout_d     = dout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        case (state_q)
            S_IDLE: begin
                if (dout_ev) overrun_d = 1'b1;
            end
            S_WR: begin
                if (din_ev) begin
                    if (fifo_full || push_rem_q == 16'd0) begin
                        overrun_d = 1'b1;
                    end else begin
                        push       = 1'b1;
                        push_rem_d = push_rem_q - 16'd1;
                    end
                end
                if (ack) begin
                    pop     = 1'b1;
                    addr_d  = addr_q + 1'b1;
                    words_d = words_q - 16'd1;
                    if (words_q == 16'd1) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (!ram_req_q && !fifo_empty) begin
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_din_d  = fmt(fifo_mem[rd_ptr_q[PW-1:0]]);
                end
            end
            S_RD_FETCH: begin
                if (dout_ev) overrun_d = 1'b1;
                if (ack) begin
                    dout_d  = fmt(bus.ram_dout);
                    addr_d  = addr_q + 1'b1;
                    words_d = words_q - 16'd1;
                    state_d = S_RD_HOLD;
                end else if (!ram_req_q) begin
                    ram_req_d  = 1'b1;
                    ram_we_d   = 1'b0;
                    ram_addr_d = addr_q;
                end
            end
            S_RD_HOLD: begin
                if (dout_ev) begin
                    if (words_q != 16'd0) begin
                        state_d = S_RD_FETCH;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ABORT: begin
                // Restart only once nothing is outstanding on the RAM port.
                if (!ram_req_q || ack) begin
                    if (words_q != 16'd0) begin
                        busy_d  = 1'b1;
                        state_d = dir_q ? S_WR : S_RD_FETCH;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (addr_ev) begin
            addr_d     = bus.addr_reg[ADDR_WIDTH-1:0];
            words_d    = new_words;
            push_rem_d = new_words;
            dir_d      = bus.addr_reg[23];
            overrun_d  = 1'b0;
            flush      = 1'b1;
            push       = 1'b0;
            pop        = 1'b0;
            if (state_q == S_IDLE) begin
                if (new_words != 16'd0) begin
                    busy_d  = 1'b1;
                    state_d = bus.addr_reg[23] ? S_WR : S_RD_FETCH;
                end
            end else begin
                // Keep any granted access as is; suppress new issue and completion effects.
                state_d    = S_ABORT;
                busy_d     = 1'b1;
                done_d     = 1'b0;
                ram_req_d  = ram_req_q & ~ack;
                ram_we_d   = ram_we_q;
                ram_addr_d = ram_addr_q;
                ram_din_d  = ram_din_q;
                dout_d     = dout_q;
            end
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_tog_q <= bus.addr_strobe;
            din_tog_q  <= bus.data_in_strobe;
            dout_tog_q <= bus.data_out_strobe;
            addr_q     <= '0;
            words_q    <= '0;
            push_rem_q <= '0;
            dir_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_req_q  <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_tog_q <= bus.addr_strobe;
            din_tog_q  <= bus.data_in_strobe;
            dout_tog_q <= bus.data_out_strobe;
            addr_q     <= addr_d;
            words_q    <= words_d;
            push_rem_q <= push_rem_d;
            dir_q      <= dir_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_req_q  <= ram_req_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= bus.data_in_reg;
    end

    assign bus.data_out_reg = dout_q;
    assign bus.ram_req      = ram_req_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_addr     = ram_addr_q;
    assign bus.ram_din      = ram_din_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_data_io_dma_ctrl.sv
// Self-checking bench for data_io_dma_ctrl: RAM responder with expected-access queue plus directed IO stimulus.
module tb_data_io_dma_ctrl;
    localparam int AW = 23;
    localparam int FD = 4;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          discard;
    } acc_t;

`ifdef DIO_BYTESWAP_EN
    localparam logic [15:0] T3_FIRST = 16'h1000;
    localparam logic [15:0] T6_DIN   = 16'h3412;
    function automatic logic [15:0] fmt(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction
`else
    localparam logic [15:0] T3_FIRST = 16'h0010;
    localparam logic [15:0] T6_DIN   = 16'h1234;
    function automatic logic [15:0] fmt(input logic [15:0] w);
        return w;
    endfunction
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_io_dma_if #(.ADDR_WIDTH(AW)) bus ();
    data_io_dma_ctrl #(.ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (.clk(clk), .reset(reset), .bus(bus));

    int            n_tests = 0;
    int            n_fail = 0;
    acc_t          exp_q[$];
    int            wr_acks = 0;
    int            rd_acks = 0;
    int            done_cnt = 0;
    int            ack_delay = 0;
    logic          stall = 1'b0;
    logic [15:0]   last_wr_din = '0;
    logic [AW-1:0] last_wr_addr = '0;

    function automatic logic [15:0] ram_val(input logic [AW-1:0] a);
        return a[15:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_acc(input logic we, input logic [AW-1:0] a, input logic [15:0] d, input logic disc);
        acc_t e;
        e.we = we; e.addr = a; e.data = d; e.discard = disc;
        exp_q.push_back(e);
    endtask

    // RAM model and per-cycle compare against the expected access stream.
    initial begin : responder
        int            wait_cnt;
        logic          prev_done;
        logic          pend_chk;
        logic [15:0]   pend_dout;
        logic [AW+16:0] cap;
        acc_t          e;
        wait_cnt = 0; prev_done = 1'b0; pend_chk = 1'b0; pend_dout = '0; cap = '0;
        bus.ram_ack = 1'b0;
        bus.ram_dout = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.ram_ack = 1'b0;
                wait_cnt = 0; pend_chk = 1'b0; prev_done = 1'b0;
            end else begin
                if (bus.done) begin
                    done_cnt++;
                    check("done_single_cycle", 32'(prev_done), 32'd0);
                end
                prev_done = bus.done;
                if (bus.ram_ack) begin
                    bus.ram_ack = 1'b0;
                    wait_cnt = 0;
                    check("req_drop_after_ack", 32'(bus.ram_req), 32'd0);
                    if (pend_chk) check("dout_after_ack", 32'(bus.data_out_reg), 32'(pend_dout));
                    pend_chk = 1'b0;
                end else if (bus.ram_req) begin
                    if (wait_cnt == 0) begin
                        cap = {bus.ram_we, bus.ram_addr, bus.ram_din};
                    end else begin
                        n_tests++;
                        if (cap !== {bus.ram_we, bus.ram_addr, bus.ram_din}) begin
                            n_fail++;
                            $display("FAIL req_stable: got 0x%0h, expected 0x%0h",
                                     {bus.ram_we, bus.ram_addr, bus.ram_din}, cap);
                        end
                    end
                    wait_cnt++;
                    if (!stall && wait_cnt > ack_delay) begin
                        bus.ram_ack = 1'b1;
                        bus.ram_dout = ram_val(bus.ram_addr);
                        if (exp_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_access: got we=%0b addr=0x%0h din=0x%0h, expected none",
                                     bus.ram_we, bus.ram_addr, bus.ram_din);
                        end else begin
                            e = exp_q.pop_front();
                            check("acc_we", 32'(bus.ram_we), 32'(e.we));
                            check("acc_addr", 32'(bus.ram_addr), 32'(e.addr));
                            if (e.we) begin
                                check("acc_din", 32'(bus.ram_din), 32'(fmt(e.data)));
                            end else begin
                                pend_chk = 1'b1;
                                pend_dout = e.discard ? bus.data_out_reg : fmt(ram_val(e.addr));
                            end
                        end
                        if (bus.ram_we) begin
                            wr_acks++;
                            last_wr_din = bus.ram_din;
                            last_wr_addr = bus.ram_addr;
                        end else begin
                            rd_acks++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_addr(input logic [31:0] v);
        bus.addr_reg = v;
        bus.addr_strobe = ~bus.addr_strobe;
        tick(1);
    endtask

    task automatic push_word(input logic [15:0] d);
        bus.data_in_reg = d;
        bus.data_in_strobe = ~bus.data_in_strobe;
        tick(3);
    endtask

    function automatic int counter(input int sel);
        case (sel)
            0:       return wr_acks;
            1:       return rd_acks;
            2:       return done_cnt;
            default: return int'(bus.ram_req);
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int target, input int budget);
        int n = 0;
        while (counter(sel) < target && n < budget) begin
            tick(1);
            n++;
        end
        n_tests++;
        if (counter(sel) < target) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected >= %0d within %0d cycles", name, counter(sel), target, budget);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish within 2 ms");
        $fatal(1, "timeout");
    end

    initial begin : main
        int d0, w0, r0;
        reset = 1'b1;
        bus.addr_strobe = 1'b1;
        bus.addr_reg = '0;
        bus.data_in_strobe = 1'b0;
        bus.data_in_reg = '0;
        bus.data_out_strobe = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tick(10);

        // 1: idle after reset, strobes already high must not fire
        check("rst_data_out", 32'(bus.data_out_reg), 32'd0);
        check("rst_ram_req", 32'(bus.ram_req), 32'd0);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_din", 32'(bus.ram_din), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done_cnt", 32'(done_cnt), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);

        // 2: 256-word write block at 0x100
        d0 = done_cnt; w0 = wr_acks;
        for (int i = 0; i < 256; i++) expect_acc(1'b1, AW'(32'h100 + i), 16'(i * 37 + 32'h1200), 1'b0);
        set_addr(32'h0180_0100);
        for (int i = 0; i < 256; i++) push_word(16'(i * 37 + 32'h1200));
        wait_for("t2_writes", 0, w0 + 256, 50);
        tick(3);
        check("t2_done_once", 32'(done_cnt - d0), 32'd1);
        check("t2_busy", 32'(bus.busy), 32'd0);
        check("t2_overrun", 32'(bus.overrun), 32'd0);
        check("t2_all_written", 32'(exp_q.size()), 32'd0);
        check("t2_last_addr", 32'(last_wr_addr), 32'h1FF);

        // 3: 256-word read block at 0x10, RAM[n]=n
        d0 = done_cnt; r0 = rd_acks;
        for (int i = 0; i < 256; i++) expect_acc(1'b0, AW'(32'h10 + i), 16'h0, 1'b0);
        set_addr(32'h0100_0010);
        for (int i = 0; i < 256; i++) begin
            wait_for("t3_read", 1, r0 + i + 1, 20);
            tick(1);
            if (i == 0) check("t3_first_dout", 32'(bus.data_out_reg), 32'(T3_FIRST));
            check("t3_dout", 32'(bus.data_out_reg), 32'(fmt(16'(32'h10 + i))));
            if (i == 255) check("t3_no_early_done", 32'(done_cnt - d0), 32'd0);
            bus.data_out_strobe = ~bus.data_out_strobe;
            tick(1);
        end
        wait_for("t3_done", 2, d0 + 1, 10);
        tick(2);
        check("t3_done_once", 32'(done_cnt - d0), 32'd1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        check("t3_overrun", 32'(bus.overrun), 32'd0);

        // 4: stalled RAM, FD+1 words -> overrun, extra word dropped
        d0 = done_cnt; w0 = wr_acks;
        stall = 1'b1;
        for (int i = 0; i < FD; i++) expect_acc(1'b1, AW'(32'h200 + i), 16'(32'hC000 + i), 1'b0);
        set_addr(32'h0180_0200);
        for (int i = 0; i < FD + 1; i++) push_word(16'(32'hC000 + i));
        check("t4_overrun", 32'(bus.overrun), 32'd1);
        check("t4_busy", 32'(bus.busy), 32'd1);
        check("t4_stalled", 32'(wr_acks - w0), 32'd0);
        stall = 1'b0;
        wait_for("t4_writes", 0, w0 + FD, 30);
        tick(10);
        check("t4_write_count", 32'(wr_acks - w0), 32'(FD));
        check("t4_all_written", 32'(exp_q.size()), 32'd0);
        set_addr(32'h0000_0000);
        tick(4);
        check("t4_busy_end", 32'(bus.busy), 32'd0);
        check("t4_overrun_cleared", 32'(bus.overrun), 32'd0);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);

        // 5: address event while a late read is pending
        d0 = done_cnt; r0 = rd_acks;
        ack_delay = 5;
        expect_acc(1'b0, AW'(32'h400), 16'h0, 1'b1);
        expect_acc(1'b0, AW'(32'h800), 16'h0, 1'b0);
        set_addr(32'h0100_0400);
        wait_for("t5_req", 3, 1, 10);
        set_addr(32'h0100_0800);
        check("t5_req_held", 32'(bus.ram_req), 32'd1);
        wait_for("t5_reads", 1, r0 + 2, 60);
        tick(2);
        check("t5_new_data", 32'(bus.data_out_reg), 32'(fmt(16'h0800)));
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        set_addr(32'h0000_0000);
        tick(4);
        check("t5_busy_end", 32'(bus.busy), 32'd0);
        check("t5_no_done_end", 32'(done_cnt - d0), 32'd0);
        check("t5_all_read", 32'(exp_q.size()), 32'd0);
        ack_delay = 0;

        // 6: address wrap at the top of the RAM
        d0 = done_cnt; w0 = wr_acks;
        expect_acc(1'b1, AW'(32'h7F_FFFF), 16'h1234, 1'b0);
        expect_acc(1'b1, AW'(32'h0), 16'hBEEF, 1'b0);
        set_addr(32'h01FF_FFFF);
        push_word(16'h1234);
        wait_for("t6_w1", 0, w0 + 1, 10);
        check("t6_din", 32'(last_wr_din), 32'(T6_DIN));
        check("t6_addr1", 32'(last_wr_addr), 32'h7F_FFFF);
        push_word(16'hBEEF);
        wait_for("t6_w2", 0, w0 + 2, 10);
        check("t6_addr2", 32'(last_wr_addr), 32'h0);
        tick(2);
        set_addr(32'h0000_0000);
        tick(4);
        check("t6_busy_end", 32'(bus.busy), 32'd0);
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
